// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Round-robin front end for a shared GCD subtract-iterate datapath.
// It grants one requester at a time and sequences the datapath through
// LOAD and RUN. The result comes back on a valid/ready response channel,
// tagged with the requester id. A captured a==0 skips the datapath,
// because the unit never terminates for a=0, b!=0. A RUN-cycle limit
// turns a stuck datapath into an error response instead of a hang.
module gcd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 4,
  parameter int MAX_ITER = 32,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int ITER_W  = $clog2(MAX_ITER)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_error,
  output logic                     busy,
  output logic [WIDTH-1:0]         gcd_a,
  output logic [WIDTH-1:0]         gcd_b,
  output logic                     gcd_load_values,
  input  logic [WIDTH-1:0]         gcd_result,
  input  logic                     gcd_is_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  b_reg, b_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [WIDTH-1:0]  result_reg, result_next;
  logic              error_reg, error_next;
  logic [ITER_W-1:0] iter_reg, iter_next;

  // Per-requester operand views of the packed request buses.
  logic [WIDTH-1:0] slot_a [NUM_REQ];
  logic [WIDTH-1:0] slot_b [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign slot_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign slot_b[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: first valid request at or above rr_ptr, wrapping.
  logic            grant_hit;
  logic [ID_W-1:0] grant_idx;
  int              cand;

  // Finds the winning requester for this cycle.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_reg) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_hit && req_valid[cand[ID_W-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  // State and captured-job registers; reset abandons any job in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
      iter_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      id_reg     <= id_next;
      result_reg <= result_next;
      error_reg  <= error_next;
      iter_reg   <= iter_next;
    end
  end

  // Next-state logic and the strobes that depend on the current state.
  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    id_next         = id_reg;
    result_next     = result_reg;
    error_next      = error_reg;
    iter_next       = iter_reg;
    req_ready       = '0;
    rsp_valid       = 1'b0;
    gcd_load_values = 1'b0;

    case (state_reg)
      IDLE: begin
        // Gated by reset_n so that every output reads 0 while reset is held.
        if (grant_hit && reset_n) begin
          req_ready[grant_idx] = 1'b1;
          a_next               = slot_a[grant_idx];
          b_next               = slot_b[grant_idx];
          id_next              = grant_idx;
          state_next           = LOAD;
        end
      end

      LOAD: begin
        if (a_reg == '0) begin
          // gcd(0,b)=b. The datapath would spin forever, so skip it.
          result_next = b_reg;
          error_next  = 1'b0;
          state_next  = RESP;
        end else begin
          gcd_load_values = 1'b1;
          iter_next       = '0;
          state_next      = RUN;
        end
      end

      RUN: begin
        if (gcd_is_valid) begin
          result_next = gcd_result;
          error_next  = 1'b0;
          state_next  = RESP;
        end else if (iter_reg == ITER_W'(MAX_ITER - 1)) begin
          result_next = '0;
          error_next  = 1'b1;
          state_next  = RESP;
        end else begin
          iter_next = iter_reg + 1'b1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // The pointer moves past the winner, so it is lowest next round.
          if (id_reg == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
          end else begin
            rr_ptr_next = id_reg + 1'b1;
          end
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign rsp_result = result_reg;
  assign rsp_id     = id_reg;
  assign rsp_error  = error_reg;
  assign gcd_a      = a_reg;
  assign gcd_b      = b_reg;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter
// Directed bench for gcd_arbiter, with a behavioural subtract-iterate GCD
// unit standing in for the datapath. It can be forced stuck to exercise
// the timeout.
module tb_gcd_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_result;
  logic [1:0]  rsp_id;
  logic        rsp_error;
  logic        busy;
  logic [3:0]  gcd_a;
  logic [3:0]  gcd_b;
  logic        gcd_load_values;
  logic [3:0]  gcd_result;
  logic        gcd_is_valid;

  int compared   = 0;
  int mismatched = 0;

  gcd_arbiter #(.NUM_REQ(4), .WIDTH(4), .MAX_ITER(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_id          (rsp_id),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .gcd_a           (gcd_a),
    .gcd_b           (gcd_b),
    .gcd_load_values (gcd_load_values),
    .gcd_result      (gcd_result),
    .gcd_is_valid    (gcd_is_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Subtract-iterate GCD unit: x-=y while x>y, else y-=x; done when y==0.
  logic [3:0] dp_x = 4'd0;
  logic [3:0] dp_y = 4'd0;
  logic       stuck = 1'b0;

  always @(posedge clock) begin
    if (gcd_load_values) begin
      dp_x <= gcd_a;
      dp_y <= gcd_b;
    end else if (dp_x > dp_y) begin
      dp_x <= dp_x - dp_y;
    end else begin
      dp_y <= dp_y - dp_x;
    end
  end

  assign gcd_result   = dp_x;
  assign gcd_is_valid = (dp_y == 4'd0) && !stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b);
    req_a[idx*4 +: 4] = a;
    req_b[idx*4 +: 4] = b;
  endtask

  // Called at a falling edge with the DUT in IDLE and requests already driven.
  // Latency is counted in cycles from the accept edge to rsp_valid.
  task automatic job(input string tag, input int exp_idx, input logic [3:0] exp_res,
                     input int exp_lat, input logic exp_err, input int exp_loads,
                     input bit drop, input int stall);
    int cyc;
    int loads;
    logic [3:0] grant;
    grant = 4'b0001 << exp_idx;
    #1;
    check({tag, " grant"}, 32'(req_ready), 32'(grant));
    @(negedge clock);
    if (drop) req_valid[exp_idx] = 1'b0;
    cyc   = 1;
    loads = 0;
    while (!rsp_valid && cyc < 200) begin
      if (gcd_load_values) loads++;
      @(negedge clock);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " loads"}, 32'(loads), 32'(exp_loads));
    check({tag, " response"}, {23'd0, rsp_result, rsp_id, rsp_error, req_ready},
          {23'd0, exp_res, 2'(exp_idx), exp_err, 4'b0000});
    $display("job %s: id=%0d result=%0d error=%0b latency=%0d",
             tag, rsp_id, rsp_result, rsp_error, cyc);
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check({tag, " stall hold"}, {22'd0, rsp_valid, rsp_result, rsp_id, req_ready},
            {22'd0, 1'b1, exp_res, 2'(exp_idx), 4'b0000});
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    check({tag, " handshake"}, {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 1'b1;
    #1;
    check("reset outputs", {10'd0, req_ready, rsp_valid, rsp_result, rsp_id, rsp_error,
                            busy, gcd_a, gcd_b, gcd_load_values}, 32'd0);
    #21 reset_n = 1'b1;
    @(negedge clock);

    // Single jobs: normal iterate, b==0, and the a==0 bypass.
    set_req(0, 4'd12, 4'd8); req_valid[0] = 1'b1;
    job("r0 12,8", 0, 4'd4, 6, 1'b0, 1, 1'b1, 0);
    set_req(1, 4'd5, 4'd0);  req_valid[1] = 1'b1;
    job("r1 5,0", 1, 4'd5, 3, 1'b0, 1, 1'b1, 0);
    set_req(2, 4'd0, 4'd7);  req_valid[2] = 1'b1;
    job("r2 0,7", 2, 4'd7, 2, 1'b0, 0, 1'b1, 0);
    set_req(3, 4'd4, 4'd4);  req_valid[3] = 1'b1;
    job("r3 4,4", 3, 4'd4, 4, 1'b0, 1, 1'b1, 0);

    // All four held valid: strict rotation starting at 0.
    set_req(0, 4'd15, 4'd10);
    set_req(1, 4'd9, 4'd6);
    set_req(2, 4'd7, 4'd3);
    set_req(3, 4'd4, 4'd4);
    req_valid = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      job("rr 15,10", 0, 4'd5, 6, 1'b0, 1, 1'b0, 0);
      job("rr 9,6",   1, 4'd3, 6, 1'b0, 1, 1'b0, 0);
      job("rr 7,3",   2, 4'd1, 8, 1'b0, 1, 1'b0, 0);
      job("rr 4,4",   3, 4'd4, 4, 1'b0, 1, 1'b0, 0);
    end

    // Consumer stalls while the other requesters are still asking.
    rsp_ready = 1'b0;
    job("stall", 0, 4'd5, 6, 1'b0, 1, 1'b0, 5);
    req_valid = 4'b0000;

    // Datapath never reports done: timeout after 32 RUN cycles.
    stuck = 1'b1;
    set_req(1, 4'd3, 4'd5); req_valid[1] = 1'b1;
    job("timeout", 1, 4'd0, 34, 1'b1, 1, 1'b1, 0);
    stuck = 1'b0;
    set_req(2, 4'd8, 4'd12); req_valid[2] = 1'b1;
    job("after timeout", 2, 4'd4, 6, 1'b0, 1, 1'b1, 0);

    // Asynchronous reset in the middle of RUN.
    set_req(1, 4'd7, 4'd3); req_valid[1] = 1'b1;
    #1;
    check("pre-reset grant", 32'(req_ready), 32'h2);
    @(negedge clock);
    req_valid[1] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid-run reset outputs", {10'd0, req_ready, rsp_valid, rsp_result, rsp_id, rsp_error,
                                    busy, gcd_a, gcd_b, gcd_load_values}, 32'd0);
    #4 reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("no stale response", {30'd0, rsp_valid, busy}, 32'd0);
    end
    // Pointer back at 0: req 0 wins over req 3, then req 3 is served.
    set_req(0, 4'd5, 4'd0);
    set_req(3, 4'd4, 4'd4);
    req_valid = 4'b1001;
    job("post-reset r0", 0, 4'd5, 3, 1'b0, 1, 1'b1, 0);
    job("post-reset r3", 3, 4'd4, 4, 1'b0, 1, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Shares one GCD subtract-iterate datapath between NUM_REQ requesters. A round-robin arbiter grants one request at a time. The block sequences the datapath through load, iterate and completion, then returns the result with the requester's id on a valid/ready response channel. It sits directly in front of the GCD unit and owns its loadValues, a and b inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, operand/result width; must match datapath
MAX_ITER, 32, RUN-cycle timeout limit; must be >= 2^(WIDTH+1)

Ports:
clock  input  1  sole clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot grant/accept, combinational in IDLE
req_a  input  NUM_REQ*WIDTH  operand a; slot i = [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand b; same packing
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_result  output  WIDTH  gcd(a,b)
rsp_id  output  clog2(NUM_REQ)  index of the granted requester
rsp_error  output  1  timeout flag, qualified by rsp_valid
busy  output  1  high in any state except IDLE
gcd_a  output  WIDTH  to datapath a
gcd_b  output  WIDTH  to datapath b
gcd_load_values  output  1  to datapath loadValues
gcd_result  input  WIDTH  from datapath result
gcd_is_valid  input  1  from datapath isValid (y==0)

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, all outputs 0. Captured a, b, id, result, error and iter count are cleared.
- Reset mid-operation aborts any job. No response is issued, and the datapath is reloaded before its next use.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Search req_valid starting at rr_ptr, upward modulo NUM_REQ. The first hit i gets req_ready[i]=1 in the same cycle.
  - On that edge, capture a_i, b_i and id=i, then go to LOAD. req_ready is 0 in all other states.
- LOAD (1 cycle):
  - If captured a==0: set result=b and error=0, do not pulse the datapath, go to RESP. This bypass is required because the datapath never terminates for a=0, b≠0.
  - Else: gcd_load_values=1 with gcd_a/gcd_b = captured values; clear iter count; go to RUN.
  - gcd_is_valid is ignored in LOAD.
- RUN:
  - gcd_load_values=0 each cycle.
  - If gcd_is_valid=1: capture gcd_result, error=0, go to RESP.
  - Else if iter==MAX_ITER-1: result=0, error=1, go to RESP.
  - Else iter++.
- RESP:
  - rsp_valid=1. rsp_result, rsp_id and rsp_error are held stable until rsp_ready.
  - On the rsp_valid&&rsp_ready edge: rr_ptr=(id+1) mod NUM_REQ, go to IDLE.
  - No new grant in the handshake cycle; the next grant is possible the following cycle.
- gcd_a/gcd_b hold the captured operands outside LOAD; their value only matters while gcd_load_values=1.
- Latency from the accept edge: rsp_valid rises after 2 + k cycles, where k = RUN cycles until is_valid. The a==0 bypass gives 2 cycles.
- Requests that are not granted must hold valid and operands. The block does not buffer them.
- Fairness: each requester waits at most NUM_REQ-1 other jobs.
- Zero-operand cases:
  - a=0, b=0 returns 0 via the bypass.
  - b=0, a≠0 returns a after 1 RUN cycle.

Test Plan:
- Single request on req 0, a=12, b=8, rsp_ready=1 -> req_ready[0] on cycle T0; gcd_load_values on T1 only; rsp_valid on T6 with result=4, id=0, error=0.
- req 1 a=5, b=0 -> result=5 with rsp_valid 3 cycles after accept. req 2 a=0, b=7 -> result=7 after 2 cycles with no gcd_load_values pulse.
- All 4 requesters held valid with distinct operands for 8 jobs -> grant order 0,1,2,3,0,1,2,3; each rsp_id matches; results correct (e.g. 15,10->5; 9,6->3; 7,3->1; 4,4->4).
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, result and id stable; no req_ready asserted; completes on the first cycle rsp_ready=1.
- Stuck datapath model with gcd_is_valid forced 0 -> rsp_valid after MAX_ITER RUN cycles (32) with error=1 and result=0; the next job runs normally.
- reset_n pulsed low mid-RUN, asynchronously -> all outputs 0 immediately and rr_ptr=0; no stale response after release; the next request on req 3 completes correctly.
